// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths, frame derivation and quadrant fold for the NCO phase engine
package nco_pkg;

    localparam int ACC_W_DEF  = 20;
    localparam int ADDR_W_DEF = 10;
    localparam int DIG_W_DEF  = 2;
    localparam int NCH_DEF    = 2;

    // Generic carrier widths so one fold function serves every lane parameterisation
    localparam int PH_MAX   = 64;
    localparam int ADDR_MAX = 32;

    typedef struct packed {
        logic                sign;
        logic [ADDR_MAX-1:0] addr;
    } fold_t;

    function automatic int calc_ndig(input int addr_w, input int dig_w);
        return (addr_w + dig_w - 1) / dig_w;
    endfunction

    function automatic int calc_frame(input int addr_w, input int dig_w);
        return calc_ndig(addr_w, dig_w) + 1;
    endfunction

    // Quadrant bit 0 mirrors the quarter-wave address, quadrant bit 1 inverts the sign
    function automatic fold_t quad_fold(input logic [PH_MAX-1:0] ph, input int acc_w,
                                        input int addr_w);
        fold_t               r;
        logic [1:0]          q;
        logic [ADDR_MAX-1:0] f;
        logic [ADDR_MAX-1:0] mask;
        q      = 2'(ph >> (acc_w - 2));
        f      = ADDR_MAX'(ph >> (acc_w - 2 - addr_w));
        mask   = (ADDR_MAX'(1) << addr_w) - ADDR_MAX'(1);
        r.addr = (q[0] ? ~f : f) & mask;
        r.sign = q[1];
        return r;
    endfunction

endpackage

// File: rtl/nco_pa_lane.sv
// rtl/nco_pa_lane.sv - one channel: accumulator, FCW shadow/active, fold and digit shifter
module nco_pa_lane
    import nco_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIG_W  = DIG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stop_i,
    input  logic             bnd_i,
    input  logic             shift_i,
    input  logic             ld_i,
    input  logic             ld_pend_i,
    input  logic             clr_pend_i,
    input  logic [ACC_W-1:0] fcw_i,
    input  logic [ACC_W-1:0] pofs_i,
    output logic [DIG_W-1:0] dig_o,
    output logic             is_o
);

    localparam int NDIG = calc_ndig(ADDR_W, DIG_W);
    localparam int SR_W = NDIG * DIG_W;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fcw_act_q, fcw_act_d;
    logic [ACC_W-1:0] fcw_shd_q, fcw_shd_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             is_q, is_d;
    logic [ACC_W-1:0] ph;
    logic [SR_W-1:0]  addr_pad;
    fold_t            fo;

    assign ph       = acc_q + pofs_i;
    assign fo       = quad_fold(PH_MAX'(ph), ACC_W, ADDR_W);
    assign addr_pad = SR_W'(fo.addr);

    always_comb begin
        acc_d     = acc_q;
        fcw_act_d = fcw_act_q;
        fcw_shd_d = ld_i ? fcw_i : fcw_shd_q;
        sr_d      = sr_q;
        dig_d     = '0;
        is_d      = is_q;
        if (stop_i) begin
            acc_d = '0;
            sr_d  = '0;
        end else if (bnd_i) begin
            // The first digit leaves directly from the fold; the rest queue in the shifter
            dig_d = addr_pad[DIG_W-1:0];
            sr_d  = addr_pad >> DIG_W;
            is_d  = fo.sign;
            acc_d = clr_pend_i ? '0 : acc_q + fcw_act_q;
            if (ld_pend_i) begin
                fcw_act_d = fcw_shd_q;
            end
        end else if (shift_i) begin
            dig_d = sr_q[DIG_W-1:0];
            sr_d  = sr_q >> DIG_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            fcw_act_q <= '0;
            fcw_shd_q <= '0;
            sr_q      <= '0;
            dig_q     <= '0;
            is_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fcw_act_q <= fcw_act_d;
            fcw_shd_q <= fcw_shd_d;
            sr_q      <= sr_d;
            dig_q     <= dig_d;
            is_q      <= is_d;
        end
    end

    assign dig_o = dig_q;
    assign is_o  = is_q;

endmodule

// File: rtl/nco_phase_engine.sv
// rtl/nco_phase_engine.sv - multi-channel phase engine with frame sequencing and pending flags
module nco_phase_engine
    import nco_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIG_W  = DIG_W_DEF,
    parameter int NCH    = NCH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 En,
    input  logic [NCH*ACC_W-1:0] fcw,
    input  logic                 fcw_ld,
    input  logic [NCH*ACC_W-1:0] pofs,
    input  logic                 clr,
    output logic                 Vld,
    output logic                 dig_vld,
    output logic [NCH*DIG_W-1:0] Aout,
    output logic [NCH-1:0]       ISout
);

    localparam int NDIG  = calc_ndig(ADDR_W, DIG_W);
    localparam int FRAME = calc_frame(ADDR_W, DIG_W);
    localparam int CNT_W = (FRAME > 2) ? $clog2(FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(NDIG - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             ld_pend_q, ld_pend_d;
    logic             clr_pend_q, clr_pend_d;
    logic             dig_vld_q, dig_vld_d;
    logic             stop;
    logic             bnd;
    logic             shift;

    assign stop  = !En;
    assign bnd   = run_q && (cnt_q == LAST_SLOT);
    assign shift = run_q && (cnt_q < LAST_SHIFT);

    always_comb begin
        cnt_d      = cnt_q;
        ld_pend_d  = ld_pend_q;
        clr_pend_d = clr_pend_q;
        dig_vld_d  = 1'b0;
        if (stop) begin
            cnt_d = LAST_SLOT;
        end else if (run_q) begin
            cnt_d = bnd ? '0 : cnt_q + CNT_W'(1);
        end
        // A new request always survives; otherwise a boundary or stop retires the flag
        if (fcw_ld) begin
            ld_pend_d = 1'b1;
        end else if (stop || bnd) begin
            ld_pend_d = 1'b0;
        end
        if (clr) begin
            clr_pend_d = 1'b1;
        end else if (stop || bnd) begin
            clr_pend_d = 1'b0;
        end
        if (!stop) begin
            dig_vld_d = bnd || shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= LAST_SLOT;
            run_q      <= 1'b0;
            ld_pend_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            dig_vld_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            run_q      <= En;
            ld_pend_q  <= ld_pend_d;
            clr_pend_q <= clr_pend_d;
            dig_vld_q  <= dig_vld_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        nco_pa_lane #(
            .ACC_W (ACC_W),
            .ADDR_W(ADDR_W),
            .DIG_W (DIG_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .stop_i    (stop),
            .bnd_i     (bnd),
            .shift_i   (shift),
            .ld_i      (fcw_ld),
            .ld_pend_i (ld_pend_q),
            .clr_pend_i(clr_pend_q),
            .fcw_i     (fcw[c*ACC_W +: ACC_W]),
            .pofs_i    (pofs[c*ACC_W +: ACC_W]),
            .dig_o     (Aout[c*DIG_W +: DIG_W]),
            .is_o      (ISout[c])
        );
    end

    assign Vld     = bnd;
    assign dig_vld = dig_vld_q;

endmodule

// File: tb/tb_nco_phase_engine.sv
// tb/tb_nco_phase_engine.sv - directed table and sequence bench for nco_phase_engine
module tb_nco_phase_engine;

    localparam int ACC_W  = 20;
    localparam int ADDR_W = 10;
    localparam int DIG_W  = 2;
    localparam int NCH    = 2;
    localparam int NDIG   = 5;
    localparam int FRAME  = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 En;
    logic [NCH*ACC_W-1:0] fcw;
    logic                 fcw_ld;
    logic [NCH*ACC_W-1:0] pofs;
    logic                 clr;
    logic                 Vld;
    logic                 dig_vld;
    logic [NCH*DIG_W-1:0] Aout;
    logic [NCH-1:0]       ISout;

    int n_chk  = 0;
    int n_fail = 0;

    logic [ADDR_W-1:0] got_a [NCH];
    logic              got_i [NCH];

    typedef struct {
        logic [ACC_W-1:0]  fcw0;
        logic [ACC_W-1:0]  fcw1;
        logic [ACC_W-1:0]  pofs0;
        logic [ACC_W-1:0]  pofs1;
        int                k;
        logic [ADDR_W-1:0] a0;
        logic              i0;
        logic [ADDR_W-1:0] a1;
        logic              i1;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    nco_phase_engine #(
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W),
        .DIG_W (DIG_W),
        .NCH   (NCH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (En),
        .fcw    (fcw),
        .fcw_ld (fcw_ld),
        .pofs   (pofs),
        .clr    (clr),
        .Vld    (Vld),
        .dig_vld(dig_vld),
        .Aout   (Aout),
        .ISout  (ISout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_vld(input string tag);
        int t;
        t = 0;
        while (Vld !== 1'b1 && t < 2 * FRAME) begin
            @(negedge clk);
            t++;
        end
        if (Vld !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no Vld within %0d cycles", tag, 2 * FRAME);
        end
    endtask

    task automatic read_frame(input string tag);
        logic dv_ok;
        dv_ok = 1'b1;
        wait_vld(tag);
        for (int c = 0; c < NCH; c++) got_a[c] = '0;
        for (int d = 0; d < NDIG; d++) begin
            @(negedge clk);
            if (dig_vld !== 1'b1) dv_ok = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                got_a[c][d*DIG_W +: DIG_W] = Aout[c*DIG_W +: DIG_W];
                if (d == 0) got_i[c] = ISout[c];
            end
        end
        check({tag, " dig_vld"}, 32'(dv_ok), 32'd1);
    endtask

    // Leaves fcw_act = {f1,f0}, acc = 0, run stopped
    task automatic prime(input logic [ACC_W-1:0] f0, input logic [ACC_W-1:0] f1);
        En = 1'b0;
        @(negedge clk);
        fcw    = {f1, f0};
        En     = 1'b1;
        fcw_ld = 1'b1;
        @(negedge clk);
        fcw_ld = 1'b0;
        wait_vld("prime");
        @(negedge clk);
        En = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv, nd, last_v, first_v;
        logic gap_ok;

        rst_n = 1'b0; En = 1'b0; fcw_ld = 1'b0; clr = 1'b0; fcw = '0; pofs = '0;
        repeat (2) @(negedge clk);
        check("reset Vld", 32'(Vld), 32'd0);
        check("reset dig_vld", 32'(dig_vld), 32'd0);
        check("reset Aout", 32'(Aout), 32'd0);
        check("reset ISout", 32'(ISout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle Vld", 32'(Vld), 32'd0);

        vecs[0] = '{20'h10000, 20'h08000, 20'h00000, 20'h00000, 1, 10'd256,  1'b0, 10'd128,  1'b0};
        vecs[1] = '{20'h10000, 20'h08000, 20'h00000, 20'h00000, 5, 10'd767,  1'b0, 10'd640,  1'b0};
        vecs[2] = '{20'h10000, 20'h08000, 20'h00000, 20'h00000, 9, 10'd256,  1'b1, 10'd895,  1'b0};
        vecs[3] = '{20'h00000, 20'h00000, 20'h40000, 20'hC0000, 0, 10'd1023, 1'b0, 10'd1023, 1'b1};
        vecs[4] = '{20'h00000, 20'h00000, 20'h40000, 20'hC0000, 3, 10'd1023, 1'b0, 10'd1023, 1'b1};
        vecs[5] = '{20'h00000, 20'h00000, 20'hC0000, 20'h40000, 2, 10'd1023, 1'b1, 10'd1023, 1'b0};
        vecs[6] = '{20'h10000, 20'h30000, 20'h40000, 20'h12345, 3, 10'd255,  1'b0, 10'd547,  1'b1};
        vecs[7] = '{20'h80001, 20'hC0000, 20'h00000, 20'h00000, 2, 10'd0,    1'b0, 10'd0,    1'b1};

        for (int i = 0; i < 8; i++) begin
            prime(vecs[i].fcw0, vecs[i].fcw1);
            pofs = {vecs[i].pofs1, vecs[i].pofs0};
            En   = 1'b1;
            for (int j = 0; j <= vecs[i].k; j++) read_frame($sformatf("v%0d f%0d", i, j));
            check($sformatf("v%0d addr0", i), 32'(got_a[0]), 32'(vecs[i].a0));
            check($sformatf("v%0d sign0", i), 32'(got_i[0]), 32'(vecs[i].i0));
            check($sformatf("v%0d addr1", i), 32'(got_a[1]), 32'(vecs[i].a1));
            check($sformatf("v%0d sign1", i), 32'(got_i[1]), 32'(vecs[i].i1));
            En = 1'b0;
            @(negedge clk);
        end

        // Vld cadence over 60 cycles from restart
        pofs = '0;
        En   = 1'b0;
        @(negedge clk);
        En = 1'b1;
        nv = 0; nd = 0; last_v = -1; first_v = -1; gap_ok = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (dig_vld === 1'b1) nd++;
            if (Vld === 1'b1) begin
                nv++;
                if (first_v < 0) first_v = t;
                if (last_v >= 0 && t - last_v != FRAME) gap_ok = 1'b0;
                last_v = t;
            end
        end
        check("cadence first Vld", 32'(first_v), 32'd1);
        check("cadence Vld count", 32'(nv), 32'd10);
        check("cadence Vld spacing", 32'(gap_ok), 32'd1);
        check("cadence dig_vld count", 32'(nd), 32'd50);

        // Wrap: acc 0xFFFFF plus step 2 lands on 0x00001
        prime(20'hFFFFF, 20'h0);
        pofs   = '0;
        fcw    = {20'h0, 20'h00002};
        fcw_ld = 1'b1;
        En     = 1'b1;
        @(negedge clk);
        fcw_ld = 1'b0;
        read_frame("wrap f0");
        read_frame("wrap f1");
        check("wrap f1 sign", 32'(got_i[0]), 32'd1);
        check("wrap f1 addr", 32'(got_a[0]), 32'd0);
        read_frame("wrap f2");
        check("wrap f2 sign", 32'(got_i[0]), 32'd0);
        check("wrap f2 addr", 32'(got_a[0]), 32'd0);

        // FCW update one cycle before a boundary, then a load coinciding with a boundary
        prime(20'h0, 20'h08000);
        En = 1'b1;
        read_frame("upd f0");
        fcw    = {20'h10000, 20'h0};
        fcw_ld = 1'b1;
        @(negedge clk);
        fcw_ld = 1'b0;
        read_frame("upd f1");
        check("upd f1 addr1", 32'(got_a[1]), 32'd128);
        read_frame("upd f2");
        check("upd f2 addr1", 32'(got_a[1]), 32'd256);
        read_frame("upd f3");
        check("upd f3 addr1", 32'(got_a[1]), 32'd512);
        wait_vld("upd b4");
        fcw    = '0;
        fcw_ld = 1'b1;
        @(negedge clk);
        fcw_ld = 1'b0;
        read_frame("upd f5");
        check("upd f5 addr1", 32'(got_a[1]), 32'd1023);
        read_frame("upd f6");
        check("upd f6 addr1", 32'(got_a[1]), 32'd767);
        read_frame("upd f7");
        check("upd f7 addr1", 32'(got_a[1]), 32'd767);

        // Clear pulse: zero phase two boundaries later
        prime(20'h10000, 20'h0);
        En = 1'b1;
        read_frame("clr f0");
        read_frame("clr f1");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        read_frame("clr f2");
        check("clr f2 addr0", 32'(got_a[0]), 32'd512);
        read_frame("clr f3");
        check("clr f3 addr0", 32'(got_a[0]), 32'd0);
        read_frame("clr f4");
        check("clr f4 addr0", 32'(got_a[0]), 32'd256);

        // Asynchronous reset in slot 2
        En = 1'b0;
        @(negedge clk);
        pofs = {20'h0, 20'hC0000};
        En   = 1'b1;
        wait_vld("rst");
        repeat (3) @(negedge clk);
        check("pre-rst Aout0", 32'(Aout[1:0]), 32'd3);
        check("pre-rst ISout0", 32'(ISout[0]), 32'd1);
        rst_n = 1'b0;
        En    = 1'b0;
        #1;
        check("rst Aout", 32'(Aout), 32'd0);
        check("rst dig_vld", 32'(dig_vld), 32'd0);
        check("rst Vld", 32'(Vld), 32'd0);
        check("rst ISout", 32'(ISout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Synchronous stop in slot 3, then restart
        En = 1'b1;
        wait_vld("stop");
        repeat (4) @(negedge clk);
        check("pre-stop dig_vld", 32'(dig_vld), 32'd1);
        En = 1'b0;
        @(negedge clk);
        check("stop Aout", 32'(Aout), 32'd0);
        check("stop dig_vld", 32'(dig_vld), 32'd0);
        check("stop Vld", 32'(Vld), 32'd0);
        check("stop ISout held", 32'(ISout[0]), 32'd1);
        En = 1'b1;
        @(negedge clk);
        check("restart Vld", 32'(Vld), 32'd1);
        read_frame("restart f0");
        check("restart addr0", 32'(got_a[0]), 32'd1023);
        check("restart sign0", 32'(got_i[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
